// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: tick input, the three raw push-buttons and the
// sequencer outputs that feed the time-counter chain and the FND display.
interface stopwatch_ctrl_if;
  logic       i_tick;
  logic       i_btn_run_stop;
  logic       i_btn_clear;
  logic       i_btn_lap;
  logic       o_tick_en;
  logic       o_run;
  logic       o_clear;
  logic       o_lap_hold;
  logic [1:0] o_state;

  // Driver side: clock divider and buttons in, sequencer outputs observed.
  modport master (
    output i_tick, i_btn_run_stop, i_btn_clear, i_btn_lap,
    input  o_tick_en, o_run, o_clear, o_lap_hold, o_state
  );

  // Sequencer side.
  modport slave (
    input  i_tick, i_btn_run_stop, i_btn_clear, i_btn_lap,
    output o_tick_en, o_run, o_clear, o_lap_hold, o_state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/clear/lap sequencer.
// Each raw button is synchronised, debounced and edge-detected into a
// one-cycle press pulse; a Moore FSM gates the 10 ms tick into the counter
// chain, issues a one-cycle clear and holds the lap (split) display freeze.
// Optional build macro STOPWATCH_LONGPRESS_CLEAR_EN: holding run_stop for
// LONG_CYC cycles while stopped clears the stopwatch.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 100_000,
  parameter int unsigned LONG_CYC     = 200_000_000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);

  // Button index: 0 = run_stop, 1 = clear, 2 = lap.
  localparam int BtnRun   = 0;
  localparam int BtnClear = 1;
  localparam int BtnLap   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STOP  = 2'b10,
    CLEAR = 2'b11
  } state_e;

  if (DEBOUNCE_CYC < 1 || LONG_CYC < 1) begin : g_bad_params
    $error("stopwatch_ctrl: DEBOUNCE_CYC and LONG_CYC must be at least 1");
  end

  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q;
  logic [2:0]     sync2_q;
  logic [2:0]     deb_q;
  logic [2:0]     deb_dly_q;
  logic [DbW-1:0] db_cnt_q [3];
  logic [2:0]     press;
  logic           long_hit;

  state_e state_q, state_d;
  logic   lap_q, lap_d;

  assign btn_raw = {bus.i_btn_lap, bus.i_btn_clear, bus.i_btn_run_stop};

  // Synchronise each button, then let the debounced level follow only after
  // the synced level has differed from it for DEBOUNCE_CYC straight cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      for (int b = 0; b < 3; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      for (int b = 0; b < 3; b++) begin
        if (sync2_q[b] == deb_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DbLast) begin
          deb_q[b]    <= sync2_q[b];
          db_cnt_q[b] <= '0;
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // A press is the first cycle the debounced level is high; release is silent.
  assign press = deb_q & ~deb_dly_q;

`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
  localparam int unsigned LgW = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
  localparam logic [LgW-1:0] LgLast = LgW'(LONG_CYC - 1);

  logic [LgW-1:0] long_cnt_q;

  // Count consecutive stopped cycles with run_stop held down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_cnt_q <= '0;
    end else if (state_q == STOP && deb_q[BtnRun]) begin
      long_cnt_q <= (long_cnt_q == LgLast) ? '0 : long_cnt_q + 1'b1;
    end else begin
      long_cnt_q <= '0;
    end
  end

  assign long_hit = (state_q == STOP) && deb_q[BtnRun] && (long_cnt_q == LgLast);
`else
  assign long_hit = 1'b0;
`endif

  // State and lap-freeze registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
    end
  end

  // Next state: run_stop outranks clear, which outranks lap; only the
  // highest-priority press that means something in this state acts.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    unique case (state_q)
      IDLE: begin
        if (press[BtnRun])        state_d = RUN;
        else if (press[BtnClear]) state_d = CLEAR;
      end
      RUN: begin
        if (press[BtnRun])        state_d = STOP;
        else if (press[BtnLap])   lap_d   = ~lap_q;
      end
      STOP: begin
        if (press[BtnRun]) begin
          state_d = RUN;
        end else if (press[BtnClear] || long_hit) begin
          state_d = CLEAR;
          lap_d   = 1'b0;
        end else if (press[BtnLap]) begin
          lap_d   = 1'b0;
        end
      end
      CLEAR: begin
        state_d = IDLE;
        lap_d   = 1'b0;
      end
    endcase
  end

  assign bus.o_run      = (state_q == RUN);
  assign bus.o_clear    = (state_q == CLEAR);
  assign bus.o_tick_en  = bus.i_tick & (state_q == RUN);
  assign bus.o_lap_hold = lap_q;
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl (DEBOUNCE_CYC=4, LONG_CYC=20).
// A behavioural model tracks the button histories and the stopwatch rules
// and is compared against the DUT every cycle; directed scenarios add
// hand-computed literal expectations.
module tb_stopwatch_ctrl;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  bit   checkEn = 1'b0;
  bit   tickEnable = 1'b0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.DEBOUNCE_CYC(DEB), .LONG_CYC(LONG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state: 0 idle, 1 running, 2 stopped, 3 clearing.
  int          mState;
  bit          mLap;
  bit          mDeb  [3];
  bit          mRose [3];
  logic [31:0] hist  [3];
  int          holdCycles;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Advance the model one clock: presses act one cycle after the debounced
  // level rises; a level flips once the last DEB synchronised samples agree.
  task automatic modelStep();
    bit p [3];
    bit raw [3];
    bit hit;
    bit allDiff;
    p   = mRose;
    hit = 1'b0;
    raw[0] = bus.i_btn_run_stop;
    raw[1] = bus.i_btn_clear;
    raw[2] = bus.i_btn_lap;
`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
    if (mState == 2 && mDeb[0]) begin
      holdCycles++;
      hit = (holdCycles >= LONG);
    end else begin
      holdCycles = 0;
    end
`endif
    case (mState)
      0: if (p[0]) mState = 1; else if (p[1]) mState = 3;
      1: if (p[0]) mState = 2; else if (p[2]) mLap = !mLap;
      2: begin
        if (p[0]) mState = 1;
        else if (p[1] || hit) begin mState = 3; mLap = 1'b0; end
        else if (p[2]) mLap = 1'b0;
      end
      default: begin mState = 0; mLap = 1'b0; end
    endcase
    for (int b = 0; b < 3; b++) begin
      hist[b] = {hist[b][30:0], raw[b]};
      allDiff = 1'b1;
      for (int i = 2; i < DEB + 2; i++) if (hist[b][i] == mDeb[b]) allDiff = 1'b0;
      mRose[b] = 1'b0;
      if (allDiff) begin
        mDeb[b]  = !mDeb[b];
        mRose[b] = mDeb[b];
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState = 0;
      mLap = 1'b0;
      holdCycles = 0;
      for (int b = 0; b < 3; b++) begin
        mDeb[b] = 1'b0; mRose[b] = 1'b0; hist[b] = '0;
      end
    end else begin
      modelStep();
    end
  end

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("state",    int'(bus.o_state),    mState);
      checkOutput("run",      int'(bus.o_run),      int'(mState == 1));
      checkOutput("clear",    int'(bus.o_clear),    int'(mState == 3));
      checkOutput("lap_hold", int'(bus.o_lap_hold), int'(mLap));
      checkOutput("tick_en",  int'(bus.o_tick_en),  int'(bus.i_tick && mState == 1));
    end
  end

  // 10 ms time base stand-in: one-cycle pulse every 5 cycles.
  initial begin
    int phase;
    phase = 0;
    bus.i_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (tickEnable) begin
        phase = (phase + 1) % 5;
        bus.i_tick = (phase == 0);
      end else begin
        bus.i_tick = 1'b0;
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic applyStimulus(input bit run, input bit clr, input bit lap, input int n);
    bus.i_btn_run_stop = run;
    bus.i_btn_clear    = clr;
    bus.i_btn_lap      = lap;
    stepCycles(n);
  endtask

  task automatic countOutputs(input int n, output int ticks, output int clears);
    ticks  = 0;
    clears = 0;
    repeat (n) begin
      stepCycles(1);
      ticks  += int'(bus.o_tick_en);
      clears += int'(bus.o_clear);
    end
  endtask

  task automatic pressRun();
    applyStimulus(1, 0, 0, 6);
    applyStimulus(0, 0, 0, 10);
  endtask

  task automatic pressLap();
    applyStimulus(0, 0, 1, 6);
    applyStimulus(0, 0, 0, 10);
  endtask

  initial begin
    int t, c, t2, c2;
    bus.i_btn_run_stop = 1'b0;
    bus.i_btn_clear    = 1'b0;
    bus.i_btn_lap      = 1'b0;
    reset = 1'b1;
    stepCycles(3);
    reset = 1'b0;
    checkEn = 1'b1;
    checkOutput("reset_state", int'(bus.o_state), 0);
    checkOutput("reset_run", int'(bus.o_run), 0);
    checkOutput("reset_clear", int'(bus.o_clear), 0);
    checkOutput("reset_lap", int'(bus.o_lap_hold), 0);
    tickEnable = 1'b1;

    // Long hold from idle gives a single press into running.
    applyStimulus(1, 0, 0, 10);
    applyStimulus(0, 0, 0, 10);
    checkOutput("hold_to_run", int'(bus.o_state), 1);
    countOutputs(20, t, c);
    checkOutput("run_ticks", t, 4);

    // Three-cycle glitch is filtered out.
    applyStimulus(1, 0, 0, 3);
    applyStimulus(0, 0, 0, 10);
    checkOutput("glitch_state", int'(bus.o_state), 1);

    // Second press stops; ticks no longer pass.
    pressRun();
    checkOutput("stop_state", int'(bus.o_state), 2);
    countOutputs(20, t, c);
    checkOutput("stop_ticks", t, 0);

    // Clear from stopped: exactly one clear cycle, then idle.
    bus.i_btn_clear = 1'b1;
    countOutputs(6, t, c);
    bus.i_btn_clear = 1'b0;
    countOutputs(10, t2, c2);
    checkOutput("clear_pulses", c + c2, 1);
    checkOutput("after_clear", int'(bus.o_state), 0);

    // Lap toggling while running, kept into stop, dropped by lap in stop.
    pressRun();
    pressLap();
    checkOutput("lap1", int'(bus.o_lap_hold), 1);
    pressLap();
    checkOutput("lap2", int'(bus.o_lap_hold), 0);
    pressLap();
    checkOutput("lap3", int'(bus.o_lap_hold), 1);
    pressRun();
    checkOutput("lap_into_stop_state", int'(bus.o_state), 2);
    checkOutput("lap_into_stop", int'(bus.o_lap_hold), 1);
    pressLap();
    checkOutput("lap_in_stop", int'(bus.o_lap_hold), 0);
    pressLap();
    checkOutput("lap_in_stop_again", int'(bus.o_lap_hold), 0);

    // Clear and run together while stopped: run wins, no clear.
    bus.i_btn_run_stop = 1'b1;
    bus.i_btn_clear    = 1'b1;
    countOutputs(6, t, c);
    bus.i_btn_run_stop = 1'b0;
    bus.i_btn_clear    = 1'b0;
    countOutputs(10, t2, c2);
    checkOutput("simul_clears", c + c2, 0);
    checkOutput("simul_state", int'(bus.o_state), 1);

    // Hold run_stop through the stop press for 35 cycles.
    applyStimulus(1, 0, 0, 35);
    applyStimulus(0, 0, 0, 10);
`ifdef STOPWATCH_LONGPRESS_CLEAR_EN
    checkOutput("long_hold", int'(bus.o_state), 0);
`else
    checkOutput("long_hold", int'(bus.o_state), 2);
`endif
    pressRun();
    checkOutput("rerun", int'(bus.o_state), 1);
    applyStimulus(1, 0, 0, 10);
    applyStimulus(0, 0, 0, 10);
    checkOutput("short_hold", int'(bus.o_state), 2);

    // Asynchronous reset mid-run with the lap freeze active.
    pressRun();
    pressLap();
    checkOutput("pre_reset_lap", int'(bus.o_lap_hold), 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_state", int'(bus.o_state), 0);
    checkOutput("mid_reset_run", int'(bus.o_run), 0);
    checkOutput("mid_reset_lap", int'(bus.o_lap_hold), 0);
    stepCycles(2);
    reset = 1'b0;
    countOutputs(15, t, c);
    checkOutput("post_reset_ticks", t, 0);
    checkOutput("post_reset_state", int'(bus.o_state), 0);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
